ps2_key_decoder: RTL and testbench

Consumes the per-frame strobes and shift-register contents of the PS/2 frame receiver and turns them into translated key events for the system bus. It synchronizes the receiver's strobes into the system clock domain and tracks prefix bytes (0xE0, 0xF0) and modifier state (Shift, Ctrl, Caps Lock). It then maps make codes to ASCII or special codes and buffers them in a small FIFO with a valid/ready handshake to the consumer.

---
 rtl/keyboard_pkg.sv | 40 ++++
 rtl/ps2_key_decoder_if.sv | 12 +
 rtl/scancode_rom.sv | 73 +++++++
 rtl/ps2_key_decoder.sv | 190 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PS/2 key decoder: prefix states,
// scancode set-2 constants and the special codes pushed for arrow keys.
package keyboard_pkg;

  localparam int unsigned CODE_W   = 8;
  localparam int unsigned N_STROBE = 4;

  // Bit positions of the receiver strobes inside the synchronizer vector
  localparam int unsigned P_DATA = 0;
  localparam int unsigned P_REL  = 1;
  localparam int unsigned P_EXT  = 2;
  localparam int unsigned P_RST  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_e;

  localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [CODE_W-1:0] SC_CAPS   = 8'h58;
  localparam logic [CODE_W-1:0] SC_UP     = 8'h75;
  localparam logic [CODE_W-1:0] SC_DOWN   = 8'h72;
  localparam logic [CODE_W-1:0] SC_LEFT   = 8'h6B;
  localparam logic [CODE_W-1:0] SC_RIGHT  = 8'h74;

  localparam logic [CODE_W-1:0] KEY_UP    = 8'h80;
  localparam logic [CODE_W-1:0] KEY_DOWN  = 8'h81;
  localparam logic [CODE_W-1:0] KEY_LEFT  = 8'h82;
  localparam logic [CODE_W-1:0] KEY_RIGHT = 8'h83;

  // The receiver shifts LSB first, so the captured byte arrives reversed
  function automatic logic [CODE_W-1:0] bit_reverse(input logic [CODE_W-1:0] b);
    return {<<{b}};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key event bus: FIFO head with valid/ready handshake toward the consumer.
interface ps2_key_decoder_if;
  import keyboard_pkg::*;

  logic [CODE_W-1:0] key_data;
  logic              key_valid;
  logic              key_ready;

  modport master (output key_data, output key_valid, input key_ready);
  modport slave  (input key_data, input key_valid, output key_ready);

endinterface

// File: rtl/scancode_rom.sv
// Combinational set-2 scancode to ASCII table; 0x00 marks an unmapped code.
module scancode_rom
  import keyboard_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              shift_i,
  output logic [CODE_W-1:0] ascii_o
);

  // Upper byte is the unshifted character, lower byte the shifted one
  logic [2*CODE_W-1:0] pair;

  always_comb begin
    pair = '0;
    case (code_i)
      8'h1C: pair = "aA";
      8'h32: pair = "bB";
      8'h21: pair = "cC";
      8'h23: pair = "dD";
      8'h24: pair = "eE";
      8'h2B: pair = "fF";
      8'h34: pair = "gG";
      8'h33: pair = "hH";
      8'h43: pair = "iI";
      8'h3B: pair = "jJ";
      8'h42: pair = "kK";
      8'h4B: pair = "lL";
      8'h3A: pair = "mM";
      8'h31: pair = "nN";
      8'h44: pair = "oO";
      8'h4D: pair = "pP";
      8'h15: pair = "qQ";
      8'h2D: pair = "rR";
      8'h1B: pair = "sS";
      8'h2C: pair = "tT";
      8'h3C: pair = "uU";
      8'h2A: pair = "vV";
      8'h1D: pair = "wW";
      8'h22: pair = "xX";
      8'h35: pair = "yY";
      8'h1A: pair = "zZ";
      8'h45: pair = "0)";
      8'h16: pair = "1!";
      8'h1E: pair = "2@";
      8'h26: pair = "3#";
      8'h25: pair = "4$";
      8'h2E: pair = "5%";
      8'h36: pair = "6^";
      8'h3D: pair = "7&";
      8'h3E: pair = "8*";
      8'h46: pair = "9(";
      8'h29: pair = "  ";
      8'h0E: pair = "`~";
      8'h4E: pair = "-_";
      8'h55: pair = "=+";
      8'h54: pair = "[{";
      8'h5B: pair = "]}";
      8'h5D: pair = "\\|";
      8'h4C: pair = ";:";
      8'h52: pair = "'\"";
      8'h41: pair = ",<";
      8'h49: pair = ".>";
      8'h4A: pair = "/?";
      8'h5A: pair = {8'h0D, 8'h0D};
      8'h66: pair = {8'h08, 8'h08};
      8'h0D: pair = {8'h09, 8'h09};
      8'h76: pair = {8'h1B, 8'h1B};
      default: pair = '0;
    endcase
    ascii_o = shift_i ? pair[CODE_W-1:0] : pair[2*CODE_W-1:CODE_W];
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 receiver strobes into translated key events, buffered in a
// small FIFO toward the system bus.
module ps2_key_decoder
  import keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               data,
  input  logic                      data_latch,
  input  logic                      release_key,
  input  logic                      extended_code,
  input  logic                      reset_required,
  ps2_key_decoder_if.master         key_if,
  output logic                      overflow,
  output logic                      kbd_reset,
  output logic                      caps_lock
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAST  = SYNC_STAGES - 1;

  logic [N_STROBE-1:0]                   strobe_async;
  logic [SYNC_STAGES-1:0][N_STROBE-1:0]  sync_q;
  logic [N_STROBE-1:0]                   prev_q, pulse_q, rise;
  logic [CODE_W-1:0]                     code_q;
  logic                                  unused_frame_bits;

  assign strobe_async      = {reset_required, extended_code, release_key, data_latch};
  assign rise              = sync_q[LAST] & ~prev_q;
  assign unused_frame_bits = ^{data[10], data[1:0]};

  // Strobe synchronizers, edge detectors and scancode capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      code_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_async};
      prev_q  <= sync_q[LAST];
      pulse_q <= rise;
      if (rise[P_DATA]) code_q <= bit_reverse(data[9:2]);
    end
  end

  prefix_state_e     state_q, state_d;
  logic              shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic              ctrl_q, ctrl_d, caps_q, caps_d;
  logic              push_q, push_d;
  logic [CODE_W-1:0] push_data_q, push_data_d;
  logic [CODE_W-1:0] rom_ascii, cased, xlat;
  logic              ext, brk;

  scancode_rom u_rom (
    .code_i  (code_q),
    .shift_i (shift_l_q | shift_r_q),
    .ascii_o (rom_ascii)
  );

  // Caps Lock flips letter case; Ctrl folds 0x40-0x7F into control codes
  always_comb begin
    cased = rom_ascii;
    if (caps_q && ((rom_ascii >= 8'h41 && rom_ascii <= 8'h5A) ||
                   (rom_ascii >= 8'h61 && rom_ascii <= 8'h7A)))
      cased = rom_ascii ^ 8'h20;
    xlat = cased;
    if (ctrl_q && cased[7:6] == 2'b01) xlat = cased & 8'h1F;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      ctrl_q      <= ctrl_d;
      caps_q      <= caps_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // Prefix tracking is applied before a coincident data byte is decoded
  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    ctrl_d      = ctrl_q;
    caps_d      = caps_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    if (pulse_q[P_EXT])
      state_d = (state_d inside {ST_BRK, ST_EXT_BRK}) ? ST_EXT_BRK : ST_EXT;
    if (pulse_q[P_REL])
      state_d = (state_d inside {ST_EXT, ST_EXT_BRK}) ? ST_EXT_BRK : ST_BRK;

    ext = state_d inside {ST_EXT, ST_EXT_BRK};
    brk = state_d inside {ST_BRK, ST_EXT_BRK};

    if (pulse_q[P_DATA]) begin
      state_d = ST_IDLE;
      case (code_q)
        SC_LSHIFT: shift_l_d = !brk;
        SC_RSHIFT: shift_r_d = !brk;
        SC_CTRL:   ctrl_d    = !brk;
        SC_CAPS:   if (!brk) caps_d = !caps_q;
        default: begin
          if (!brk && ext) begin
            push_d = 1'b1;
            case (code_q)
              SC_UP:    push_data_d = KEY_UP;
              SC_DOWN:  push_data_d = KEY_DOWN;
              SC_LEFT:  push_data_d = KEY_LEFT;
              SC_RIGHT: push_data_d = KEY_RIGHT;
              default:  push_d      = 1'b0;
            endcase
          end else if (!brk && rom_ascii != '0) begin
            push_d      = 1'b1;
            push_data_d = xlat;
          end
        end
      endcase
    end

    if (pulse_q[P_RST]) begin
      state_d   = ST_IDLE;
      shift_l_d = 1'b0;
      shift_r_d = 1'b0;
      ctrl_d    = 1'b0;
    end
  end

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CODE_W-1:0] key_data_q, head_d;
  logic              key_valid_q, ovf_q;
  logic              pop, full, wr_en;

  assign pop      = key_valid_q && key_if.key_ready;
  assign full     = count_q == CNT_W'(FIFO_DEPTH);
  assign wr_en    = push_q && (!full || pop);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  // Bypass when the entry being written becomes the new head
  assign head_d   = (wr_en && rd_ptr_d == wr_ptr_q) ? push_data_q : mem_q[rd_ptr_d];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_data_q  <= '0;
      key_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_data_q  <= head_d;
      key_valid_q <= count_d != '0;
      ovf_q       <= ovf_q | (push_q && full && !pop);
    end
  end

  assign key_if.key_data  = key_data_q;
  assign key_if.key_valid = key_valid_q;
  assign overflow         = ovf_q;
  assign kbd_reset        = pulse_q[P_RST];
  assign caps_lock        = caps_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random
// key sequences scored against a character-level keyboard model.
module tb_ps2_key_decoder;
  import keyboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] data;
  logic        data_latch, release_key, extended_code, reset_required;
  logic        overflow, kbd_reset, caps_lock;
  int          total = 0;
  int          bad   = 0;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .data           (data),
    .data_latch     (data_latch),
    .release_key    (release_key),
    .extended_code  (extended_code),
    .reset_required (reset_required),
    .key_if         (bus),
    .overflow       (overflow),
    .kbd_reset      (kbd_reset),
    .caps_lock      (caps_lock)
  );

  always #5 clk = ~clk;

  // Keyboard model state
  logic [7:0] mq[$];
  bit m_ovf, m_ext, m_brk, m_sl, m_sr, m_ctrl, m_caps;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] dig_shift [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
    8'h26, 8'h2A, 8'h28};
  logic [7:0] arrow_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  function automatic void model_clear();
    mq.delete();
    m_ovf = 0; m_ext = 0; m_brk = 0; m_sl = 0; m_sr = 0; m_ctrl = 0; m_caps = 0;
  endfunction

  function automatic void model_push(input logic [7:0] v);
    if (mq.size() < 8) mq.push_back(v);
    else m_ovf = 1;
  endfunction

  function automatic void model_data(input logic [7:0] code);
    bit e = m_ext;
    bit b = m_brk;
    bit sh = m_sl | m_sr;
    bit found = 0;
    int ch = 0;
    m_ext = 0;
    m_brk = 0;
    if (code == 8'h12) m_sl = !b;
    else if (code == 8'h59) m_sr = !b;
    else if (code == 8'h14) m_ctrl = !b;
    else if (code == 8'h58) begin
      if (!b) m_caps = !m_caps;
    end else if (!b && e) begin
      for (int i = 0; i < 4; i++)
        if (arrow_codes[i] == code) model_push(8'(8'h80 + i));
    end else if (!b) begin
      for (int i = 0; i < 26; i++)
        if (let_codes[i] == code) begin
          found = 1;
          ch = ((sh ^ m_caps) ? 65 : 97) + i;
        end
      for (int i = 0; i < 10; i++)
        if (dig_codes[i] == code) begin
          found = 1;
          ch = sh ? int'(dig_shift[i]) : 48 + i;
        end
      if (code == 8'h29) begin
        found = 1;
        ch = 32;
      end
      if (found) begin
        if (m_ctrl && ch >= 64 && ch <= 127) ch = ch % 32;
        model_push(8'(ch));
      end
    end
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] code);
    logic [10:0] f;
    f = 11'($urandom);
    for (int i = 0; i < 8; i++) f[9-i] = code[i];
    return f;
  endfunction

  // which: 0 data byte, 1 release, 2 extended, 3 device reset
  task automatic strobe(input int which, input logic [7:0] code);
    if (which == 0) data = frame_of(code);
    case (which)
      0: data_latch = 1;
      1: release_key = 1;
      2: extended_code = 1;
      default: reset_required = 1;
    endcase
    repeat (3) @(posedge clk);
    #1;
    data_latch = 0; release_key = 0; extended_code = 0; reset_required = 0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic key(input bit e, input bit b, input logic [7:0] code);
    if (e) begin strobe(2, 8'h00); m_ext = 1; end
    if (b) begin strobe(1, 8'h00); m_brk = 1; end
    strobe(0, code);
    model_data(code);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    logic [7:0] exp;
    while (bus.key_valid === 1'b1 && guard < 16) begin
      total++;
      if (mq.size() == 0) begin
        bad++;
        $display("FAIL %s: extra key_data=%h, none expected", tag, bus.key_data);
      end else begin
        exp = mq.pop_front();
        if (bus.key_data !== exp) begin
          bad++;
          $display("FAIL %s: key_data=%h expected %h", tag, bus.key_data, exp);
        end
      end
      bus.key_ready = 1;
      @(posedge clk);
      #1;
      bus.key_ready = 0;
      guard++;
    end
    total++;
    if (mq.size() != 0 || bus.key_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: key_valid=%b with %0d events still expected", tag, bus.key_valid, mq.size());
      mq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.key_data, bus.key_valid, overflow, kbd_reset, caps_lock} !== 12'h000) begin
      bad++;
      $display("FAIL reset: data=%h valid=%b ovf=%b kbr=%b caps=%b, all zero required",
               bus.key_data, bus.key_valid, overflow, kbd_reset, caps_lock);
    end
    rst = 0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_make_a();
    data = frame_of(8'h1C);
    data_latch = 1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.key_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: key_valid=%b after edge 4, expected 0", bus.key_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.key_valid !== 1'b1 || bus.key_data !== 8'h61) begin
      bad++;
      $display("FAIL make_a: valid=%b data=%h after edge 5, expected 1/61", bus.key_valid, bus.key_data);
    end
    data_latch = 0;
    repeat (4) @(posedge clk);
    #1;
    bus.key_ready = 1;
    @(posedge clk);
    #1;
    bus.key_ready = 0;
    total++;
    if (bus.key_valid !== 1'b0) begin
      bad++;
      $display("FAIL pop_a: key_valid=%b after pop, expected 0", bus.key_valid);
    end
  endtask

  task automatic test_shift();
    key(0, 0, 8'h12);
    key(0, 0, 8'h1C);
    key(0, 1, 8'h12);
    key(0, 0, 8'h1C);
    drain("shift");
  endtask

  task automatic test_caps_ctrl();
    key(0, 0, 8'h58);
    key(0, 1, 8'h58);
    key(0, 0, 8'h1C);
    total++;
    if (caps_lock !== m_caps) begin
      bad++;
      $display("FAIL caps_on: caps_lock=%b expected %b", caps_lock, m_caps);
    end
    drain("caps");
    key(0, 0, 8'h14);
    key(0, 0, 8'h1C);
    drain("ctrl");
    key(0, 1, 8'h14);
    key(0, 0, 8'h58);
    key(0, 1, 8'h58);
    total++;
    if (caps_lock !== m_caps) begin
      bad++;
      $display("FAIL caps_off: caps_lock=%b expected %b", caps_lock, m_caps);
    end
  endtask

  task automatic test_extended();
    for (int i = 0; i < 4; i++) key(1, 0, arrow_codes[i]);
    key(1, 1, 8'h75);
    key(0, 0, 8'h1C);
    drain("extended");
  endtask

  task automatic test_overflow();
    logic [7:0] code;
    for (int i = 0; i < 9; i++) begin
      key(0, 0, let_codes[$urandom_range(0, 25)]);
      if (i >= 7) begin
        total++;
        if (overflow !== m_ovf) begin
          bad++;
          $display("FAIL overflow_%0d: overflow=%b expected %b", i + 1, overflow, m_ovf);
        end
      end
    end
    code = let_codes[$urandom_range(0, 25)];
    data = frame_of(code);
    data_latch = 1;
    repeat (4) @(posedge clk);
    #1;
    bus.key_ready = 1;
    total++;
    if (bus.key_valid !== 1'b1 || bus.key_data !== mq[0]) begin
      bad++;
      $display("FAIL full_head: valid=%b data=%h expected 1/%h", bus.key_valid, bus.key_data, mq[0]);
    end
    @(posedge clk);
    #1;
    bus.key_ready = 0;
    data_latch = 0;
    void'(mq.pop_front());
    model_data(code);
    repeat (6) @(posedge clk);
    #1;
    drain("push_pop_full");
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: overflow=%b expected 1", overflow);
    end
  endtask

  task automatic test_bat();
    key(0, 0, 8'h12);
    reset_required = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (kbd_reset !== 1'b0) begin
      bad++;
      $display("FAIL kbd_reset_early: kbd_reset=%b expected 0", kbd_reset);
    end
    @(posedge clk);
    #1;
    total++;
    if (kbd_reset !== 1'b1) begin
      bad++;
      $display("FAIL kbd_reset_pulse: kbd_reset=%b expected 1", kbd_reset);
    end
    @(posedge clk);
    #1;
    total++;
    if (kbd_reset !== 1'b0) begin
      bad++;
      $display("FAIL kbd_reset_width: kbd_reset=%b expected 0", kbd_reset);
    end
    reset_required = 0;
    repeat (6) @(posedge clk);
    #1;
    m_ext = 0; m_brk = 0; m_sl = 0; m_sr = 0; m_ctrl = 0;
    key(0, 0, 8'h1C);
    drain("after_bat");
  endtask

  task automatic test_random();
    logic [7:0] code;
    int r;
    bit e, b;
    for (int batch = 0; batch < 30; batch++) begin
      for (int k = 0; k < 5; k++) begin
        r = $urandom_range(0, 99);
        e = (r < 15);
        b = ($urandom_range(0, 2) == 0);
        if (r == 99) begin
          strobe(3, 8'h00);
          m_ext = 0; m_brk = 0; m_sl = 0; m_sr = 0; m_ctrl = 0;
        end else begin
          if (e) begin
            case ($urandom_range(0, 5))
              0, 1, 2, 3: code = arrow_codes[$urandom_range(0, 3)];
              4: code = 8'h14;
              default: code = 8'h7D;
            endcase
          end else begin
            r = $urandom_range(0, 41);
            if (r < 26) code = let_codes[r];
            else if (r < 36) code = dig_codes[r - 26];
            else case (r)
              36: code = 8'h29;
              37: code = 8'h12;
              38: code = 8'h59;
              39: code = 8'h14;
              40: code = 8'h58;
              default: code = 8'h05;
            endcase
          end
          key(e, b, code);
        end
      end
      total++;
      if (caps_lock !== m_caps || overflow !== m_ovf) begin
        bad++;
        $display("FAIL random_state_%0d: caps=%b ovf=%b expected %b/%b",
                 batch, caps_lock, overflow, m_caps, m_ovf);
      end
      drain("random");
    end
  endtask

  task automatic test_rst_mid();
    key(0, 0, 8'h58);
    key(0, 0, 8'h12);
    key(0, 0, let_codes[$urandom_range(0, 25)]);
    key(0, 0, let_codes[$urandom_range(0, 25)]);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    total++;
    if ({bus.key_data, bus.key_valid, overflow, kbd_reset, caps_lock} !== 12'h000) begin
      bad++;
      $display("FAIL rst_mid: data=%h valid=%b ovf=%b kbr=%b caps=%b, all zero required",
               bus.key_data, bus.key_valid, overflow, kbd_reset, caps_lock);
    end
    key(0, 0, 8'h1C);
    drain("after_rst");
  endtask

  initial begin
    data = '0;
    data_latch = 0; release_key = 0; extended_code = 0; reset_required = 0;
    bus.key_ready = 0;
    test_reset();
    test_make_a();
    test_shift();
    test_caps_ctrl();
    test_extended();
    test_overflow();
    test_bat();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
